md_unit: RTL and testbench
==========================

// Module: md_unit
// PURPOSE
//   Multiply/divide sequencer for the 5-stage pipeline: owns the HI/LO registers and
//   executes mult/multu/div/divu as multi-cycle operations issued from the E stage.
//   Raises busy while an operation runs and produces the D-stage stall request that
//   the hazard unit ORs into Stall_F/Stall_D/Flush_E.
// PARAMETERS
//   MULT_CYCLES  5   busy cycles for mult/multu (>=1)
//   DIV_CYCLES   10  busy cycles for div/divu (>=1)
// PORTS
//   clk        in   1   system clock, rising edge
//   reset      in   1   synchronous, active-high reset
//   start      in   1   E-stage instruction is an MD op; sampled on the rising edge
//   md_op      in   3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   src_a      in   32  rs operand, already forwarded
//   src_b      in   32  rt operand, already forwarded
//   md_use_D   in   1   D-stage instruction is mult/multu/div/divu/mthi/mtlo/mfhi/mflo
//   hi         out  32  HI register
//   lo         out  32  LO register
//   busy       out  1   multi-cycle operation in progress
//   stall_md   out  1   stall request to the hazard unit
// BEHAVIOUR
//   Reset: state IDLE, counter 0, hi=0, lo=0, busy=0, pending results 0.
//   States: IDLE, RUN. Down-counter cnt of width clog2(max(MULT_CYCLES,DIV_CYCLES)+1).
//   IDLE, start & md_op in {0..3}: at that edge compute result into pending_hi/lo,
//     load cnt = MULT_CYCLES or DIV_CYCLES, go to RUN.
//   IDLE, start & md_op==4: hi<=src_a at that edge; md_op==5: lo<=src_a. No busy.
//   IDLE, start & md_op in {6,7}: no effect.
//   RUN: busy=1; cnt decrements each edge; on the edge where cnt goes 1->0,
//     hi<=pending_hi, lo<=pending_lo, go to IDLE.
//   Net timing: busy high for exactly N cycles after the start edge. New HI/LO become
//     visible in the first cycle with busy=0.
//   start while RUN: ignored (the stall guarantees it never happens; the bench checks
//     that HI/LO and cnt are unaffected).
//   hi/lo keep their old values throughout RUN, so mfhi/mflo still read stale values.
//     stall_md prevents this in the pipeline.
//   stall_md = md_use_D & (busy | start). Combinational, so the start cycle stalls too.
//   Arithmetic:
//     MULT: 64-bit signed product, {hi,lo}.
//     MULTU: 64-bit unsigned product.
//     DIV: lo = quotient truncated toward zero; hi = remainder, with the sign of the dividend.
//     DIVU: unsigned quotient and remainder.
//     Divide by zero (div/divu): lo=32'hFFFF_FFFF, hi=src_a.
//     DIV 32'h8000_0000 / 32'hFFFF_FFFF: lo=32'h8000_0000, hi=0.
//   Reset mid-RUN: aborts the operation. Pending result is discarded, hi=lo=0, busy=0
//     on the next cycle.
//   Reset has priority over start in the same cycle.
// TESTING
//   1 reset asserted 2 cycles -> hi=0, lo=0, busy=0, stall_md=0 even with md_use_D=1.
//   2 MULT src_a=-3, src_b=5 -> busy high exactly 5 cycles; then hi=32'hFFFF_FFFF,
//     lo=32'hFFFF_FFF1.
//   3 MULTU 32'hFFFF_FFFF * 2 -> hi=1, lo=32'hFFFF_FFFE. DIV -7/2 -> busy 10 cycles;
//     then lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF. DIVU 7/0 -> lo=32'hFFFF_FFFF, hi=7.
//   4 MTHI 32'h1234_5678 while idle -> hi updated next cycle, busy stays 0.
//     MTLO during RUN -> ignored, lo holds the MD result at the end.
//   5 md_use_D=1 with start=1, then during RUN -> stall_md=1 for 1+N cycles and 0
//     after; with md_use_D=0 -> stall_md=0 throughout.
//   6 reset at the 3rd RUN cycle of a DIV -> busy=0 next cycle, hi=lo=0, and a
//     following MULT 6*7 gives lo=42, hi=0.

Source files
------------

// File: rtl/md_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | md_unit : multi-cycle multiply/divide sequencer owning the HI/LO registers |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        md_use_D,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        stall_md
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_MULT_CNT = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] C_DIV_CNT  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] C_CNT_ONE  = CNT_W'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic [31:0]      pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;

    logic [63:0] w_prod_s, w_prod_u;
    logic        w_a_neg, w_b_neg, w_b_zero;
    logic [31:0] w_a_mag, w_b_mag, w_b_safe_s, w_b_safe_u;
    logic [31:0] w_sq_mag, w_sr_mag, w_sq, w_sr, w_uq, w_ur;
    logic [31:0] w_res_hi, w_res_lo;

    assign w_prod_s = $signed({{32{src_a[31]}}, src_a}) * $signed({{32{src_b[31]}}, src_b});
    assign w_prod_u = {32'd0, src_a} * {32'd0, src_b};

    // Signed divide on magnitudes: avoids the 0x80000000 / -1 overflow and gives
    // truncation toward zero with the remainder taking the dividend's sign.
    assign w_a_neg    = src_a[31];
    assign w_b_neg    = src_b[31];
    assign w_b_zero   = (src_b == 32'd0);
    assign w_a_mag    = w_a_neg ? (~src_a + 32'd1) : src_a;
    assign w_b_mag    = w_b_neg ? (~src_b + 32'd1) : src_b;
    assign w_b_safe_s = w_b_zero ? 32'd1 : w_b_mag;
    assign w_b_safe_u = w_b_zero ? 32'd1 : src_b;
    assign w_sq_mag   = w_a_mag / w_b_safe_s;
    assign w_sr_mag   = w_a_mag % w_b_safe_s;
    assign w_sq       = (w_a_neg ^ w_b_neg) ? (~w_sq_mag + 32'd1) : w_sq_mag;
    assign w_sr       = w_a_neg ? (~w_sr_mag + 32'd1) : w_sr_mag;
    assign w_uq       = src_a / w_b_safe_u;
    assign w_ur       = src_a % w_b_safe_u;

    always_comb begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        case (md_op[1:0])
            2'd0: {w_res_hi, w_res_lo} = w_prod_s;
            2'd1: {w_res_hi, w_res_lo} = w_prod_u;
            2'd2: begin
                w_res_hi = w_b_zero ? src_a : w_sr;
                w_res_lo = w_b_zero ? 32'hFFFF_FFFF : w_sq;
            end
            default: begin
                w_res_hi = w_b_zero ? src_a : w_ur;
                w_res_lo = w_b_zero ? 32'hFFFF_FFFF : w_uq;
            end
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (md_op)
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            pend_hi_d = w_res_hi;
                            pend_lo_d = w_res_lo;
                            cnt_d     = md_op[1] ? C_DIV_CNT : C_MULT_CNT;
                            state_d   = S_RUN;
                        end
                        3'd4:    hi_d = src_a;
                        3'd5:    lo_d = src_a;
                        default: ;
                    endcase
                end
            end
            default: begin
                // start is deliberately ignored here; the pipeline stall keeps it low.
                cnt_d = cnt_q - C_CNT_ONE;
                if (cnt_q == C_CNT_ONE) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

    assign hi       = hi_q;
    assign lo       = lo_q;
    assign busy     = (state_q == S_RUN);
    assign stall_md = md_use_D & (busy | start);

endmodule
`default_nettype wire

// File: tb/tb_md_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_md_unit : directed scoreboard bench for the md_unit HI/LO sequencer     |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_md_unit;

    logic        clk = 1'b0;
    logic        reset, start, md_use_D;
    logic [2:0]  md_op;
    logic [31:0] src_a, src_b;
    logic [31:0] hi, lo;
    logic        busy, stall_md;

    int n_assert = 0;
    int n_fail   = 0;
    logic [63:0] sb[$];
    logic [31:0] model_hi, model_lo;

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .md_op(md_op),
        .src_a(src_a), .src_b(src_b), .md_use_D(md_use_D),
        .hi(hi), .lo(lo), .busy(busy), .stall_md(stall_md)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one MD op, count busy/stall cycles, check stale HI/LO during RUN,
    // then pop the scoreboard entry when busy drops.
    task automatic run_md(input string tag, input logic [2:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input int n, input bit use_d, input bit inject);
        int busy_cnt  = 0;
        int stall_cnt = 0;
        logic [63:0] res;
        logic [31:0] old_hi = model_hi;
        logic [31:0] old_lo = model_lo;
        @(negedge clk);
        start = 1'b1; md_op = op; src_a = a; src_b = b; md_use_D = use_d;
        sb.push_back({exp_hi, exp_lo});
        #1;
        chk({tag, "_stall_start"}, 32'(stall_md), 32'(use_d));
        if (stall_md) stall_cnt++;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (!busy) break;
            busy_cnt++;
            if (stall_md) stall_cnt++;
            chk({tag, "_stale_hi"}, hi, old_hi);
            chk({tag, "_stale_lo"}, lo, old_lo);
            start = inject && (k == 2);
            md_op = 3'd5;
            src_a = 32'hDEAD_BEEF;
            src_b = 32'd0;
        end
        chk({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(n));
        chk({tag, "_stall_cycles"}, 32'(stall_cnt), use_d ? 32'(n + 1) : 32'd0);
        chk({tag, "_stall_after"}, 32'(stall_md), 32'd0);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            res = sb.pop_front();
            chk({tag, "_hi"}, hi, res[63:32]);
            chk({tag, "_lo"}, lo, res[31:0]);
        end
        model_hi = exp_hi;
        model_lo = exp_lo;
        start = 1'b0;
        md_use_D = 1'b0;
    endtask

    task automatic mt(input string tag, input logic [2:0] op, input logic [31:0] a);
        @(negedge clk);
        start = 1'b1; md_op = op; src_a = a;
        @(negedge clk);
        start = 1'b0;
        if (op == 3'd4) model_hi = a;
        if (op == 3'd5) model_lo = a;
        chk({tag, "_hi"}, hi, model_hi);
        chk({tag, "_lo"}, lo, model_lo);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; md_op = 3'd7; src_a = 0; src_b = 0; md_use_D = 1'b1;
        model_hi = 0; model_lo = 0;
        repeat (2) @(negedge clk);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_stall", 32'(stall_md), 32'd0);
        reset = 1'b0; md_use_D = 1'b0;

        run_md("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 5, 1'b1, 1'b0);
        run_md("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE, 5, 1'b0, 1'b0);
        run_md("mult_min", 3'd0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0, 5, 1'b0, 1'b0);
        run_md("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 1'b1, 1'b0);
        run_md("div_7_m2", 3'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD, 10, 1'b0, 1'b0);
        run_md("divu_7_0", 3'd3, 32'd7, 32'd0, 32'd7, 32'hFFFF_FFFF, 10, 1'b0, 1'b0);
        run_md("div_m5_0", 3'd2, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 10, 1'b0, 1'b0);
        run_md("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10, 1'b0, 1'b0);
        run_md("divu_big", 3'd3, 32'hFFFF_FFFF, 32'd10, 32'd5, 32'h1999_9999, 10, 1'b0, 1'b0);

        mt("mthi", 3'd4, 32'h1234_5678);
        mt("mtlo", 3'd5, 32'hCAFE_F00D);
        mt("noop6", 3'd6, 32'h5555_5555);
        mt("noop7", 3'd7, 32'hAAAA_AAAA);

        run_md("mtlo_in_run", 3'd1, 32'd3, 32'd4, 32'd0, 32'd12, 5, 1'b0, 1'b1);

        // Reset at the 3rd RUN cycle of a DIV aborts it.
        @(negedge clk);
        start = 1'b1; md_op = 3'd2; src_a = 32'd100; src_b = 32'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_busy_before", 32'(busy), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        model_hi = 0; model_lo = 0;
        repeat (12) @(negedge clk);
        chk("abort_hi_late", hi, 32'd0);
        chk("abort_lo_late", lo, 32'd0);
        run_md("mult_6_7", 3'd0, 32'd6, 32'd7, 32'd0, 32'd42, 5, 1'b0, 1'b0);

        // Reset wins over a start in the same cycle.
        @(negedge clk);
        reset = 1'b1; start = 1'b1; md_op = 3'd4; src_a = 32'h0BAD_0BAD;
        @(negedge clk);
        md_op = 3'd0;
        @(negedge clk);
        reset = 1'b0; start = 1'b0;
        chk("rst_prio_hi", hi, 32'd0);
        chk("rst_prio_busy", 32'(busy), 32'd0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
